// File: rtl/calc_sequencer_if.sv
// ALU handshake bundle between the calculator sequencer (master) and the shared ALU (slave).
interface calc_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_result, alu_ovf
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_result, alu_ovf
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: decodes keypad codes into digit entry and operators and
// sequences the shared multi-cycle ALU through a start/done handshake.
module calc_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [4:0]             keycode,
    input  logic                   new_key,
    calc_sequencer_if.master       alu,
    output logic [WIDTH-1:0]       x,
    output logic                   busy,
    output logic                   error
);
    localparam int unsigned MaxDig = WIDTH / 4;
    localparam int unsigned NDigW  = $clog2(MaxDig + 1);
    localparam logic [7:0]  TmoLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StEntry, StExec, StError} state_e;
    typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpNone = 2'b11} op_e;

    state_e           state_q, state_d;
    op_e              pend_q, pend_d;
    op_e              next_op_q, next_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [NDigW-1:0] ndig_q, ndig_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             start_q, start_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic key_digit, key_op, key_eq, key_clr, key_ce;

    assign key_digit = new_key && !keycode[4];
    assign key_op    = new_key && (keycode inside {5'h10, 5'h11, 5'h12});
    assign key_eq    = new_key && (keycode == 5'h13);
    assign key_clr   = new_key && (keycode == 5'h14);
    assign key_ce    = new_key && (keycode == 5'h15);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        next_op_d = next_op_q;
        acc_d     = acc_q;
        entry_d   = entry_q;
        ndig_d    = ndig_q;
        tmo_d     = tmo_q;
        start_d   = 1'b0;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;

        if (key_clr) begin
            // CLEAR wins in every state; a late alu_done then lands in ENTRY and is ignored.
            state_d   = StEntry;
            pend_d    = OpNone;
            next_op_d = OpNone;
            acc_d     = '0;
            entry_d   = '0;
            ndig_d    = '0;
            tmo_d     = '0;
            op_d      = '0;
            a_d       = '0;
            b_d       = '0;
        end else begin
            unique case (state_q)
                StEntry: begin
                    if (key_digit) begin
                        if (ndig_q < NDigW'(MaxDig)) begin
                            entry_d = {entry_q[WIDTH-5:0], keycode[3:0]};
                            ndig_d  = ndig_q + 1'b1;
                        end
                    end else if (key_op || key_eq) begin
                        if (pend_q == OpNone) begin
                            acc_d = entry_q;
                            if (key_op) begin
                                entry_d = '0;
                                ndig_d  = '0;
                                pend_d  = op_e'(keycode[1:0]);
                            end
                        end else if (key_op && ndig_q == '0) begin
                            pend_d = op_e'(keycode[1:0]);
                        end else begin
                            state_d   = StExec;
                            start_d   = 1'b1;
                            op_d      = pend_q;
                            a_d       = acc_q;
                            b_d       = (ndig_q != '0) ? entry_q : '0;
                            tmo_d     = '0;
                            next_op_d = key_op ? op_e'(keycode[1:0]) : OpNone;
                        end
                    end else if (key_ce) begin
                        entry_d = '0;
                        ndig_d  = '0;
                    end
                end
                StExec: begin
                    tmo_d = tmo_q + 8'd1;
                    if (alu.alu_done) begin
                        if (alu.alu_ovf) begin
                            state_d = StError;
                        end else begin
                            state_d = StEntry;
                            acc_d   = alu.alu_result;
                            entry_d = '0;
                            ndig_d  = '0;
                            pend_d  = next_op_q;
                        end
                    end else if (tmo_q == TmoLast) begin
                        state_d = StError;
                    end
                end
                StError: begin
                end
                default: state_d = StEntry;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StEntry;
            pend_q    <= OpNone;
            next_op_q <= OpNone;
            acc_q     <= '0;
            entry_q   <= '0;
            ndig_q    <= '0;
            tmo_q     <= '0;
            start_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            next_op_q <= next_op_d;
            acc_q     <= acc_d;
            entry_q   <= entry_d;
            ndig_q    <= ndig_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign alu.alu_start = start_q;
    assign alu.alu_op    = op_q;
    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;

    // Display follows the entry once a digit is typed, otherwise the accumulator.
    assign x     = (state_q == StError) ? {(WIDTH / 4){4'hE}} :
                   (ndig_q != '0) ? entry_q : acc_q;
    assign busy  = (state_q == StExec);
    assign error = (state_q == StError);
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expected ALU launches are queued by the stimulus and
// checked by a monitor; a responder models the ALU latency and result.
module tb_calc_sequencer;
    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 255;

    localparam logic [4:0] KAdd = 5'h10;
    localparam logic [4:0] KSub = 5'h11;
    localparam logic [4:0] KMul = 5'h12;
    localparam logic [4:0] KEq  = 5'h13;
    localparam logic [4:0] KClr = 5'h14;
    localparam logic [4:0] KCe  = 5'h15;
    localparam logic [4:0] KIgn = 5'h16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [4:0]   keycode = '0;
    logic         new_key = 1'b0;
    logic [W-1:0] x;
    logic         busy;
    logic         error;

    calc_sequencer_if #(.WIDTH(W)) alu_if ();

    calc_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .keycode (keycode),
        .new_key (new_key),
        .alu     (alu_if),
        .x       (x),
        .busy    (busy),
        .error   (error)
    );

    always #100 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;       // 0: ALU never answers
        logic [15:0] res;
        logic        ovf;
        int          busy_len;  // -1: not checked
    } txn_t;

    txn_t exp_q[$];
    txn_t rsp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        keycode = k;
        new_key = 1'b1;
        @(negedge clk);
        new_key = 1'b0;
    endtask

    task automatic expect_launch(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input int lat,
                                 input logic [15:0] res, input logic ovf, input int blen);
        txn_t t;
        t.op = op; t.a = a; t.b = b; t.lat = lat; t.res = res; t.ovf = ovf; t.busy_len = blen;
        exp_q.push_back(t);
        rsp_q.push_back(t);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle after exec", {31'd0, busy}, 32'd0);
    endtask

    // ALU responder
    initial begin
        alu_if.alu_done   = 1'b0;
        alu_if.alu_result = '0;
        alu_if.alu_ovf    = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && alu_if.alu_start && rsp_q.size() > 0) begin
                txn_t r;
                r = rsp_q.pop_front();
                if (r.lat > 0) begin
                    repeat (r.lat - 1) @(negedge clk);
                    alu_if.alu_done   = 1'b1;
                    alu_if.alu_result = r.res;
                    alu_if.alu_ovf    = r.ovf;
                    @(negedge clk);
                    alu_if.alu_done   = 1'b0;
                    alu_if.alu_ovf    = 1'b0;
                end
            end
        end
    end

    // Launch monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && alu_if.alu_start) begin
                txn_t t;
                int   n;
                chk("launch expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    chk("alu_op", {30'd0, alu_if.alu_op}, {30'd0, t.op});
                    chk("alu_a", {16'd0, alu_if.alu_a}, {16'd0, t.a});
                    chk("alu_b", {16'd0, alu_if.alu_b}, {16'd0, t.b});
                    n = 0;
                    while (busy && n < 600) begin
                        n++;
                        @(negedge clk);
                    end
                    if (t.busy_len >= 0) chk("busy cycles", n, t.busy_len);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset x", {16'd0, x}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset error", {31'd0, error}, 32'd0);
        chk("reset alu_start", {31'd0, alu_if.alu_start}, 32'd0);
        chk("reset alu_op", {30'd0, alu_if.alu_op}, 32'd0);
        chk("reset alu_a", {16'd0, alu_if.alu_a}, 32'd0);
        chk("reset alu_b", {16'd0, alu_if.alu_b}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Digit entry saturates at four digits
        press(5'h1); press(5'h2); press(5'h3); press(5'h4);
        chk("four digits", {16'd0, x}, 32'h1234);
        press(5'h5);
        chk("fifth digit dropped", {16'd0, x}, 32'h1234);
        press(5'h1F);
        chk("ignored key", {16'd0, x}, 32'h1234);
        press(KCe);
        chk("clear entry", {16'd0, x}, 32'h0000);

        // Simple add, 10-cycle ALU
        press(KClr);
        press(5'h1); press(5'h2);
        press(KAdd);
        chk("x shows acc", {16'd0, x}, 32'h0012);
        press(5'h5);
        chk("x shows entry", {16'd0, x}, 32'h0005);
        expect_launch(2'b00, 16'h0012, 16'h0005, 10, 16'h0017, 1'b0, 10);
        press(KEq);
        wait_idle();
        chk("add result", {16'd0, x}, 32'h0017);
        chk("add error", {31'd0, error}, 32'd0);
        press(KIgn);
        chk("0x16 ignored", {16'd0, x}, 32'h0017);

        // Chain MUL then ADD; second ALU answers in the start cycle
        press(KClr);
        press(5'h2); press(KMul); press(5'h3);
        expect_launch(2'b10, 16'h0002, 16'h0003, 3, 16'h0006, 1'b0, 3);
        press(KAdd);
        wait_idle();
        chk("chain partial", {16'd0, x}, 32'h0006);
        press(5'h4);
        expect_launch(2'b00, 16'h0006, 16'h0004, 1, 16'h000A, 1'b0, 1);
        press(KEq);
        wait_idle();
        chk("chain final", {16'd0, x}, 32'h000A);
        press(5'h5);
        press(KEq);  // pend_op is NONE: no launch
        repeat (3) @(negedge clk);
        chk("equals without op", {16'd0, x}, 32'h0005);

        // Operator replacement
        press(KClr);
        press(5'h9); press(KAdd); press(KSub); press(5'h2);
        expect_launch(2'b01, 16'h0009, 16'h0002, 2, 16'h0007, 1'b0, 2);
        press(KEq);
        wait_idle();
        chk("replaced op result", {16'd0, x}, 32'h0007);

        // Digit during EXEC is dropped
        press(KClr);
        press(5'h3); press(KAdd); press(5'h1);
        expect_launch(2'b00, 16'h0003, 16'h0001, 8, 16'h0004, 1'b0, 8);
        press(KEq);
        press(5'h7);
        wait_idle();
        chk("digit in exec dropped", {16'd0, x}, 32'h0004);
        press(5'h8);
        chk("entry cleared", {16'd0, x}, 32'h0008);

        // CLEAR during EXEC, late alu_done ignored
        press(KClr);
        press(5'h5); press(KAdd); press(5'h6);
        expect_launch(2'b00, 16'h0005, 16'h0006, 10, 16'h000B, 1'b0, 2);
        press(KEq);
        press(KClr);
        repeat (15) @(negedge clk);
        chk("clear in exec x", {16'd0, x}, 32'h0000);
        chk("clear in exec busy", {31'd0, busy}, 32'd0);

        // Overflow -> ERROR
        press(5'h4); press(KMul); press(5'h5);
        expect_launch(2'b10, 16'h0004, 16'h0005, 4, 16'h0000, 1'b1, 4);
        press(KEq);
        wait_idle();
        chk("ovf error", {31'd0, error}, 32'd1);
        chk("ovf x", {16'd0, x}, 32'hEEEE);
        press(5'h1); press(KAdd);
        chk("error keys ignored", {16'd0, x}, 32'hEEEE);
        press(KClr);
        chk("error cleared", {31'd0, error}, 32'd0);
        chk("error clear x", {16'd0, x}, 32'h0000);

        // Timeout after TMO cycles of busy
        press(5'h1); press(KAdd); press(5'h2);
        expect_launch(2'b00, 16'h0001, 16'h0002, 0, 16'h0000, 1'b0, TMO);
        press(KEq);
        wait_idle();
        chk("timeout error", {31'd0, error}, 32'd1);
        chk("timeout x", {16'd0, x}, 32'hEEEE);
        press(KClr);

        // Async reset mid-EXEC
        press(5'h1); press(KAdd); press(5'h2);
        expect_launch(2'b00, 16'h0001, 16'h0002, 0, 16'h0000, 1'b0, -1);
        press(KEq);
        repeat (5) @(negedge clk);
        #20 rstn = 1'b0;
        #1;
        chk("async rst x", {16'd0, x}, 32'd0);
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst alu_a", {16'd0, alu_if.alu_a}, 32'd0);
        chk("async rst alu_b", {16'd0, alu_if.alu_b}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        press(5'h6);
        chk("after reset entry", {16'd0, x}, 32'h0006);

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("all launches seen", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
